// File: rtl/biquad_mac_sequencer.sv
// Direct-form-I biquad sequencer driving a single MAC16 accumulator wrapper.
// Optional BIQUAD_SAT_COUNT_EN adds a saturating 16-bit sat_count output.
`timescale 1ns/1ps
module biquad_mac_sequencer #(
  parameter int unsigned MAC_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_sample,
  input  logic [15:0] coef_b0,
  input  logic [15:0] coef_b1,
  input  logic [15:0] coef_b2,
  input  logic [15:0] coef_a1,
  input  logic [15:0] coef_a2,
  output logic        out_valid,
  output logic [15:0] out_sample,
  output logic        mac_rst,
  output logic        mac_ce,
  output logic [15:0] mac_a,
  output logic [15:0] mac_b,
  input  logic [31:0] mac_result,
  output logic        sat_flag
`ifdef BIQUAD_SAT_COUNT_EN
  ,
  output logic [15:0] sat_count
`endif
);

  typedef enum logic [1:0] {IDLE, CLEAR, ISSUE, DRAIN} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic        clear_q;
  logic [15:0] x0_q, b0_q, b1_q, b2_q, na1_q, na2_q;
  logic [15:0] x1, x2, y1, y2;
  logic [15:0] term_a, term_b;
  logic signed [32:0] rnd, shifted;
  logic [15:0] conv_y;
  logic        conv_sat;

  function automatic logic [15:0] neg_sat(input logic [15:0] v);
    return (v == 16'h8000) ? 16'h7FFF : (~v + 16'd1);
  endfunction

  // The MAC must be cleared for the whole accept cycle and during any reset.
  assign mac_rst = rst | clear_q;

  always_comb begin
    term_a = '0;
    term_b = '0;
    case (cnt)
      8'd0: begin term_a = b0_q;  term_b = x0_q; end
      8'd1: begin term_a = b1_q;  term_b = x1;   end
      8'd2: begin term_a = b2_q;  term_b = x2;   end
      8'd3: begin term_a = na1_q; term_b = y1;   end
      8'd4: begin term_a = na2_q; term_b = y2;   end
      default: begin term_a = '0; term_b = '0; end
    endcase
  end

  // Q4.28 -> Q2.14, round half up, then clamp.
  always_comb begin
    rnd      = $signed({mac_result[31], mac_result}) + 33'sd8192;
    shifted  = rnd >>> 14;
    conv_y   = shifted[15:0];
    conv_sat = 1'b0;
    if (shifted > 33'sd32767) begin
      conv_y   = 16'h7FFF;
      conv_sat = 1'b1;
    end else if (shifted < -33'sd32768) begin
      conv_y   = 16'h8000;
      conv_sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_sample <= '0;
      sat_flag   <= 1'b0;
      clear_q    <= 1'b0;
      mac_ce     <= 1'b0;
      mac_a      <= '0;
      mac_b      <= '0;
      cnt        <= '0;
      x0_q       <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
      b2_q       <= '0;
      na1_q      <= '0;
      na2_q      <= '0;
      x1         <= '0;
      x2         <= '0;
      y1         <= '0;
      y2         <= '0;
`ifdef BIQUAD_SAT_COUNT_EN
      sat_count  <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            x0_q     <= in_sample;
            b0_q     <= coef_b0;
            b1_q     <= coef_b1;
            b2_q     <= coef_b2;
            na1_q    <= neg_sat(coef_a1);
            na2_q    <= neg_sat(coef_a2);
            clear_q  <= 1'b1;
            in_ready <= 1'b0;
            cnt      <= '0;
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          clear_q <= 1'b0;
          mac_ce  <= 1'b1;
          mac_a   <= term_a;
          mac_b   <= term_b;
          cnt     <= 8'd1;
          state   <= ISSUE;
        end
        ISSUE: begin
          if (cnt == 8'd5) begin
            mac_a <= '0;
            mac_b <= '0;
            cnt   <= '0;
            state <= DRAIN;
          end else begin
            mac_a <= term_a;
            mac_b <= term_b;
            cnt   <= cnt + 8'd1;
          end
        end
        DRAIN: begin
          if (cnt == 8'(MAC_LATENCY - 1)) begin
            mac_ce     <= 1'b0;
            out_valid  <= 1'b1;
            out_sample <= conv_y;
            sat_flag   <= conv_sat;
            x2         <= x1;
            x1         <= x0_q;
            y2         <= y1;
            y1         <= conv_y;
            in_ready   <= 1'b1;
            cnt        <= '0;
            state      <= IDLE;
`ifdef BIQUAD_SAT_COUNT_EN
            if (conv_sat && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
`endif
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/biquad_mac_sequencer.md
Name: biquad_mac_sequencer

Overview:
- Initiator/driver for the MAC16 accumulator wrapper.
- Accepts one Q2.14 audio sample per handshake and runs one direct-form-I biquad evaluation. It issues the five coefficient×operand terms to the MAC, waits out the MAC pipeline, then reads back the Q4.28 accumulator.
- Rounds and saturates the accumulator to Q2.14, emits the output sample and updates the x/y history.
- Sits between the audio sample stream and a single MAC16 wrapper instance.

Parameters:
- MAC_LATENCY, 2, MAC edges from operand sampling (ce=1) until the accumulator reflects that term.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  sequencer can accept a sample (high only in IDLE)
- in_sample  in  16  x[n], signed Q2.14
- coef_b0, coef_b1, coef_b2, coef_a1, coef_a2  in  16 each  signed Q2.14 coefficients; y = b0x0 + b1x1 + b2x2 - a1y1 - a2y2
- out_valid  out  1  one-cycle pulse, out_sample valid
- out_sample  out  16  y[n], signed Q2.14
- mac_rst  out  1  to MAC rst (clears accumulator)
- mac_ce  out  1  to MAC ce
- mac_a  out  16  to MAC a_in (coefficient)
- mac_b  out  16  to MAC b_in (sample/history)
- mac_result  in  32  from MAC result, signed Q4.28
- sat_flag  out  1  last out_sample was saturated

Behaviour:
Reset values:
- State IDLE; in_ready=1.
- out_valid=0, out_sample=0, sat_flag=0.
- mac_rst=1 while rst is high, 0 otherwise.
- mac_ce=0, mac_a=0, mac_b=0.
- History x1, x2, y1, y2 = 0.
- rst mid-evaluation aborts immediately to IDLE. No out_valid is produced and history is cleared.

Handshake:
- Accept occurs on an edge where in_valid & in_ready; call this edge E0.
- in_sample and all five coefficients are latched at E0. Coefficient changes after E0 do not affect the current evaluation.

FSM and timing:
- IDLE: in_ready=1. On accept, go to CLEAR.
- CLEAR (E0..E1): mac_rst=1, mac_ce=0.
- ISSUE (E1..E6): 5 cycles, mac_ce=1. Term k is presented during E(k+1)..E(k+2); the MAC samples it at E(k+2). Order:
  - b0·x
  - b1·x1
  - b2·x2
  - (−a1)·y1
  - (−a2)·y2
- Negation saturates: −(0x8000) is presented as 0x7FFF.
- DRAIN (MAC_LATENCY cycles): mac_ce=1, mac_a=mac_b=0.
- CAPTURE at edge E(6+MAC_LATENCY), which is E8 at the default:
  - Register out_sample and sat_flag.
  - out_valid=1 for exactly one cycle.
  - Shift history: x2←x1, x1←x, y2←y1, y1←out_sample.
  - Return to IDLE. in_ready is high in the same cycle that out_valid is high.
- Throughput: one sample per 7+MAC_LATENCY cycles (9 at the default). The earliest next accept is E(7+MAC_LATENCY).

Conversion:
- Compute r = (sign-extended 33-bit mac_result + 2^13) >>> 14 (round half up).
- If r > 32767: out=0x7FFF, sat_flag=1. If r < −32768: out=0x8000, sat_flag=1. Otherwise out=r[15:0], sat_flag=0.
- Feedback history always stores the saturated value.

Other rules:
- In non-ISSUE/DRAIN states, mac_a and mac_b are 0 and mac_ce=0.
- in_valid while not in IDLE is ignored (not accepted, not lost — the source holds it).

Optional Feature:
- Macro: BIQUAD_SAT_COUNT_EN.
- With the macro: adds output port sat_count (16-bit). It increments at each CAPTURE with sat_flag=1, holds at 0xFFFF, and is cleared by rst.
- Without the macro: sat_count is absent. sat_flag behaviour is unchanged.

Test Plan:
- Single gain: b0=0x2000, others 0, x=0x4000 → out_valid pulse at E8, out_sample=0x2000, sat_flag=0; mac_rst high only E0..E1; mac_ce high E1..E8.
- Recursive impulse: b0=0x4000, a1=0xE000 (−0.5), rest 0; samples 0x4000, 0, 0 → outputs 0x4000, 0x2000, 0x1000.
- Saturation: b0=b1=0x7FFF, x=0x7FFF twice → both outputs 0x7FFF with sat_flag=1; history y1=0x7FFF. With BIQUAD_SAT_COUNT_EN, sat_count=2.
- Negation edge: a1=0x8000, y1 preloaded via a prior output 0x4000 (b0=0x4000, x=0x4000), then x=0 → term mac_a=0x7FFF, output 0x7FFF after rounding (r=32767), sat_flag=0.
- Back-to-back: in_valid held high with 4 samples → accepts spaced exactly 9 cycles; in_ready low E0..E8 each time; no sample dropped or duplicated.
- Reset mid-op: assert rst at E4 for 1 cycle → no out_valid; mac_rst=1 that cycle; in_ready=1 after; next sample x=0x4000 with b1=0x4000 only → output 0 (history cleared).
